// File: rtl/sha_padder.sv
`timescale 1ns/1ps
// SHA-2 message padder: absorbs a byte stream and emits complete padded blocks
// (message | 0x80 | zeros | big-endian bit length), spilling into an extra block when needed.
module sha_padder #(
  parameter int IN_BYTES    = 4,
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_BYTES   = BLOCK_BYTES / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*IN_BYTES-1:0]         din,
  input  logic [$clog2(IN_BYTES+1)-1:0] din_nbytes,
  input  logic                          din_valid,
  input  logic                          din_last,
  output logic                          din_ready,
  output logic [8*BLOCK_BYTES-1:0]      blk_data,
  output logic                          blk_valid,
  output logic                          blk_last,
  input  logic                          blk_ready
);

  localparam int NB_W      = $clog2(IN_BYTES + 1);
  localparam int PTR_W     = $clog2(BLOCK_BYTES + 1);
  localparam int LEN_W     = 8 * LEN_BYTES;
  localparam int CNT_W     = LEN_W - 3;
  localparam int LEN_START = BLOCK_BYTES - LEN_BYTES;

  typedef enum logic [1:0] {ABSORB, PAD, LENB, EMIT} state_t;

  state_t                   state_q, state_d;
  state_t                   ret_q, ret_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         bytecnt_q, bytecnt_d;
  logic                     pad_pend_q, pad_pend_d;
  logic                     last_q, last_d;
  logic [8*BLOCK_BYTES-1:0] data_q, data_d;

  logic [NB_W-1:0]  n_eff;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_sum;
  logic [PTR_W-1:0] pad_ptr;
  logic             in_fire;
  logic             short_pad;
  logic [LEN_W-1:0] len_bits;

  assign din_ready = (state_q == ABSORB);
  assign blk_valid = (state_q == EMIT);
  assign blk_last  = last_q;
  assign blk_data  = data_q;

  assign in_fire   = din_valid && (state_q == ABSORB);
  assign n_eff     = (din_nbytes > NB_W'(IN_BYTES)) ? NB_W'(IN_BYTES) : din_nbytes;
  assign ptr_inc   = din_last ? PTR_W'(n_eff) : PTR_W'(IN_BYTES);
  assign ptr_sum   = ptr_q + ptr_inc;
  // After a full-block last beat the buffer was cleared, so padding restarts at byte 0.
  assign pad_ptr   = pad_pend_q ? '0 : ptr_q;
  assign short_pad = (pad_ptr < PTR_W'(LEN_START));
  assign len_bits  = {bytecnt_q, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ABSORB;
      ret_q      <= ABSORB;
      ptr_q      <= '0;
      bytecnt_q  <= '0;
      pad_pend_q <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      ptr_q      <= ptr_d;
      bytecnt_q  <= bytecnt_d;
      pad_pend_q <= pad_pend_d;
      last_q     <= last_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    ptr_d      = ptr_q;
    bytecnt_d  = bytecnt_q;
    pad_pend_d = pad_pend_q;
    last_d     = last_q;
    unique case (state_q)
      ABSORB: begin
        if (in_fire) begin
          ptr_d     = ptr_sum;
          bytecnt_d = bytecnt_q + CNT_W'(ptr_inc);
          if (ptr_sum == PTR_W'(BLOCK_BYTES)) begin
            state_d    = EMIT;
            last_d     = 1'b0;
            ret_d      = din_last ? PAD : ABSORB;
            pad_pend_d = din_last;
          end else if (din_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        state_d    = EMIT;
        pad_pend_d = 1'b0;
        last_d     = short_pad;
        ret_d      = short_pad ? ABSORB : LENB;
      end
      LENB: begin
        state_d = EMIT;
        last_d  = 1'b1;
        ret_d   = ABSORB;
      end
      EMIT: begin
        if (blk_ready) begin
          state_d = ret_q;
          ptr_d   = '0;
          last_d  = 1'b0;
          if (last_q) begin
            bytecnt_d  = '0;
            pad_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ABSORB;
    endcase
  end

  // Byte gi of the block lives at data_q[8*(BLOCK_BYTES-1-gi) +: 8] (first byte is MSB).
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
    localparam int  SLOT_BASE = (gi / IN_BYTES) * IN_BYTES;
    localparam int  LANE      = gi % IN_BYTES;
    localparam bit  IS_LEN    = (gi >= LEN_START);

    logic [7:0] cur;
    logic [7:0] len_byte;
    logic [7:0] nxt;

    assign cur = data_q[8*(BLOCK_BYTES-1-gi) +: 8];

    if (IS_LEN) begin : g_len
      assign len_byte = len_bits[8*(BLOCK_BYTES-1-gi) +: 8];
    end else begin : g_nolen
      assign len_byte = 8'h00;
    end

    always_comb begin
      nxt = cur;
      unique case (state_q)
        ABSORB: begin
          if (in_fire && (ptr_q == PTR_W'(SLOT_BASE)) && (!din_last || (int'(n_eff) > LANE)))
            nxt = din[8*(IN_BYTES-1-LANE) +: 8];
        end
        PAD: begin
          if (PTR_W'(gi) == pad_ptr)
            nxt = 8'h80;
          else if (PTR_W'(gi) > pad_ptr)
            nxt = (short_pad && IS_LEN) ? len_byte : 8'h00;
        end
        LENB: nxt = len_byte;
        EMIT: begin
          if (blk_ready)
            nxt = 8'h00;
        end
        default: nxt = cur;
      endcase
    end

    assign data_d[8*(BLOCK_BYTES-1-gi) +: 8] = nxt;
  end

endmodule

// File: tb/tb_sha_padder.sv
`timescale 1ns/1ps
// Bench for sha_padder: three parameterisations share one stimulus bus; a reference
// padding model fills a scoreboard that a block monitor drains.
module tb_sha_padder;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   din_w;
  logic [3:0]    nb_w;
  logic          din_valid, din_last, blk_ready;
  int            sel;

  logic          v0, v1, v2, r0, r1, r2;
  logic          bv0, bv1, bv2, bl0, bl1, bl2;
  logic [511:0]  bd0, bd1;
  logic [1023:0] bd2;

  logic          rdy, bv, bl;
  logic [1023:0] bd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1023:0] d;
    logic          l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];

  always #5 clk = ~clk;

  assign v0 = din_valid && (sel == 0);
  assign v1 = din_valid && (sel == 1);
  assign v2 = din_valid && (sel == 2);

  sha_padder #(.IN_BYTES(1), .BLOCK_BYTES(64)) u_b1 (
    .clk(clk), .rst(rst), .din(din_w[63:56]), .din_nbytes(nb_w[0:0]),
    .din_valid(v0), .din_last(din_last), .din_ready(r0),
    .blk_data(bd0), .blk_valid(bv0), .blk_last(bl0), .blk_ready(blk_ready));

  sha_padder #(.IN_BYTES(4), .BLOCK_BYTES(64)) u_b4 (
    .clk(clk), .rst(rst), .din(din_w[63:32]), .din_nbytes(nb_w[2:0]),
    .din_valid(v1), .din_last(din_last), .din_ready(r1),
    .blk_data(bd1), .blk_valid(bv1), .blk_last(bl1), .blk_ready(blk_ready));

  sha_padder #(.IN_BYTES(8), .BLOCK_BYTES(128)) u_w8 (
    .clk(clk), .rst(rst), .din(din_w), .din_nbytes(nb_w),
    .din_valid(v2), .din_last(din_last), .din_ready(r2),
    .blk_data(bd2), .blk_valid(bv2), .blk_last(bl2), .blk_ready(blk_ready));

  always_comb begin
    rdy = r0; bv = bv0; bl = bl0; bd = {512'd0, bd0};
    if (sel == 1) begin
      rdy = r1; bv = bv1; bl = bl1; bd = {512'd0, bd1};
    end else if (sel == 2) begin
      rdy = r2; bv = bv2; bl = bl2; bd = bd2;
    end
  end

  // Reference padding: message, 0x80, zeros, big-endian bit length in the last bb/8 bytes.
  function automatic void push_expected(int bb);
    int n, lb, nblk, tot;
    logic [127:0] bits;
    n    = msg_q.size();
    lb   = bb / 8;
    nblk = (n + 1 + lb + bb - 1) / bb;
    tot  = nblk * bb;
    bits = 128'(n) << 3;
    for (int b = 0; b < nblk; b++) begin
      exp_t e;
      e.d = '0;
      e.l = (b == nblk - 1);
      for (int j = 0; j < bb; j++) begin
        int p;
        logic [7:0] v;
        p = b * bb + j;
        if (p < n)             v = msg_q[p];
        else if (p == n)       v = 8'h80;
        else if (p >= tot - lb) v = bits[8*(tot-1-p) +: 8];
        else                   v = 8'h00;
        e.d[8*(bb-1-j) +: 8] = v;
      end
      exp_q.push_back(e);
    end
  endfunction

  // Block monitor: every accepted block is compared with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (!rst && bv && blk_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block sel=%0d got block last=%0b required no block", sel, bl);
      end else begin
        e = exp_q.pop_front();
        if (bd !== e.d || bl !== e.l) begin
          idx = -1;
          for (int k = 127; k >= 0; k--)
            if (idx < 0 && bd[8*k +: 8] !== e.d[8*k +: 8]) idx = 127 - k;
          errors++;
          $display("FAIL block sel=%0d first_diff_byte_from_msb=%0d last got %0b required %0b data got %h required %h",
                   sel, idx, bl, e.l, bd[1023:512] ^ bd[511:0], e.d[1023:512] ^ e.d[511:0]);
        end else begin
          $display("block sel=%0d last=%0b ok (%0d pending)", sel, bl, exp_q.size());
        end
      end
    end
  end

  task automatic make_msg(input int n, input int seed);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'((i * 37 + seed) & 255));
  endtask

  task automatic make_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  // Drives msg_q on the selected instance; returns on the negedge after the final accept.
  task automatic send(input int inb, input bit partial, input int nb_force);
    int n, i, guard, k;
    bit done, lst;
    n = msg_q.size();
    i = 0;
    done = 0;
    if (!partial) push_expected(sel == 2 ? 128 : 64);
    $display("send sel=%0d bytes=%0d partial=%0b", sel, n, partial);
    while (!done) begin
      k   = (n - i < inb) ? n - i : inb;
      lst = !partial && (n - i <= inb);
      @(negedge clk);
      din_w = '0;
      for (int j = 0; j < k; j++) din_w[63-8*j -: 8] = msg_q[i+j];
      nb_w      = (lst && nb_force >= 0) ? 4'(nb_force) : 4'(k);
      din_last  = lst;
      din_valid = 1'b1;
      guard = 0;
      while (!rdy && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (guard >= 300) begin
        errors++;
        $display("FAIL din_ready_timeout sel=%0d got ready=%0b required 1 within 300 cycles", sel, rdy);
      end
      @(posedge clk);
      i += k;
      if (lst || (partial && i >= n)) done = 1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({r0, r1, r2} !== 3'b111) begin
      errors++; $display("FAIL reset_din_ready got %b required 111", {r0, r1, r2});
    end
    checks++;
    if ({bv0, bv1, bv2} !== 3'b000) begin
      errors++; $display("FAIL reset_blk_valid got %b required 000", {bv0, bv1, bv2});
    end
    checks++;
    if ({bl0, bl1, bl2} !== 3'b000) begin
      errors++; $display("FAIL reset_blk_last got %b required 000", {bl0, bl1, bl2});
    end
    checks++;
    if (bd0 !== '0 || bd1 !== '0 || bd2 !== '0) begin
      errors++; $display("FAIL reset_blk_data got nonzero required all zero");
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_abc();
    int lat;
    sel = 0;
    make_abc();
    send(1, 0, -1);
    lat = 1;
    while (!bv && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL abc_latency got %0d cycles required 2", lat);
    end
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL abc_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_empty();
    sel = 0;
    msg_q.delete();
    send(1, 0, -1);
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL empty_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_boundary();
    int guard, gap;
    sel = 0;
    make_msg(55, 11);
    send(1, 0, -1);
    wait_drain();
    make_msg(56, 5);
    send(1, 0, -1);
    guard = 0;
    while (!bv && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!bv && gap < 10);
    checks++;
    if (gap !== 2) begin
      errors++; $display("FAIL lenb_gap got %0d cycles required 2", gap);
    end
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL boundary_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_full_block();
    sel = 1;
    make_msg(64, 200);
    send(4, 0, -1);
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL full_block_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_nbytes_clamp();
    sel = 1;
    make_msg(8, 77);
    send(4, 0, 7);
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL clamp_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_stall();
    int guard;
    logic [1023:0] snap_d;
    logic snap_l;
    sel = 1;
    @(posedge clk);
    #1 blk_ready = 1'b0;
    make_msg(5, 3);
    send(4, 0, -1);
    guard = 0;
    while (!bv && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bv !== 1'b1) begin
      errors++; $display("FAIL stall_valid got %0b required 1", bv);
    end
    snap_d = bd;
    snap_l = bl;
    din_w = 64'hDEAD_BEEF_CAFE_F00D;
    nb_w = 4'd4;
    din_last = 1'b1;
    din_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bv !== 1'b1 || bd !== snap_d || bl !== snap_l) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got valid=%0b last=%0b same=%0b required valid=1 last=%0b same=1",
                 c, bv, bl, bd === snap_d, snap_l);
      end
      checks++;
      if (rdy !== 1'b0) begin
        errors++; $display("FAIL stall_din_ready cycle=%0d got %0b required 0", c, rdy);
      end
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    @(posedge clk);
    #1 blk_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bv !== 1'b0) begin
        errors++; $display("FAIL stall_single_release cycle=%0d got valid=%0b required 0", c, bv);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL stall_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    sel = 1;
    make_msg(55, 90);
    send(4, 0, -1);
    make_msg(3, 41);
    send(4, 0, -1);
    make_msg(60, 13);
    send(4, 0, -1);
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL b2b_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_wide();
    sel = 2;
    make_abc();
    send(8, 0, -1);
    make_msg(112, 21);
    send(8, 0, -1);
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL wide_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_message();
    sel = 2;
    make_msg(16, 9);
    send(8, 1, -1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (r2 !== 1'b1 || bv2 !== 1'b0 || bl2 !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got ready=%0b valid=%0b last=%0b required 1 0 0", r2, bv2, bl2);
    end
    checks++;
    if (bd2 !== '0) begin
      errors++; $display("FAIL midrst_data got nonzero required all zero");
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bv2 !== 1'b0) begin
        errors++; $display("FAIL midrst_idle cycle=%0d got valid=%0b required 0", c, bv2);
      end
    end
    make_abc();
    send(8, 0, -1);
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL midrst_drain got %0d pending required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 0;
    din_w     = '0;
    nb_w      = '0;
    din_valid = 1'b0;
    din_last  = 1'b0;
    blk_ready = 1'b1;
    test_reset();
    test_abc();
    test_empty();
    test_boundary();
    test_full_block();
    test_nbytes_clamp();
    test_stall();
    test_back_to_back();
    test_wide();
    test_reset_mid_message();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
